// File: rtl/dpsk_demodulator_if.sv
// dpsk_demodulator_if: serial input and recovered-data/status bundle for the DPSK demodulator.
interface dpsk_demodulator_if #(parameter int ERRW = 16);
    logic            rx_bit;
    logic            rx_valid;
    logic            dec_bit;
    logic            dec_valid;
    logic            locked;
    logic            sync_lost;
    logic [ERRW-1:0] err_count;
    modport master (output rx_bit, rx_valid, input dec_bit, dec_valid, locked, sync_lost, err_count);
    modport slave  (input rx_bit, rx_valid, output dec_bit, dec_valid, locked, sync_lost, err_count);
endinterface

// File: rtl/dpsk_demodulator.sv
// dpsk_demodulator: differential decoder followed by a self-synchronising PRBS7 lock/BER checker.
// Optional saturating error counter enabled by `define DPSK_DEMOD_ERRCNT_EN.
module dpsk_demodulator #(
    parameter int LOCK_CNT    = 16,
    parameter int WIN         = 64,
    parameter int LOSS_THRESH = 8,
    parameter int ERRW        = 16
) (
    input logic               clk,
    input logic               rst,
    dpsk_demodulator_if.slave bus
);
    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int PW = $clog2(WIN);
    localparam int EW = $clog2(LOSS_THRESH + 1);

    typedef enum logic [1:0] {SEED, VERIFY, LOCKED} state_e;

    logic          ref_q, dec_bit_q, dec_valid_q;
    state_e        state_q, state_d;
    logic [6:0]    s_q, s_d;
    logic [2:0]    seed_cnt_q, seed_cnt_d;
    logic [MW-1:0] match_cnt_q, match_cnt_d;
    logic [PW-1:0] win_pos_q, win_pos_d;
    logic [EW-1:0] win_err_q, win_err_d, win_err_inc;
    logic          sync_lost_q, sync_lost_d;
    logic          p, mismatch;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ref_q       <= 1'b0;
            dec_bit_q   <= 1'b0;
            dec_valid_q <= 1'b0;
        end else begin
            dec_valid_q <= bus.rx_valid;
            if (bus.rx_valid) begin
                dec_bit_q <= bus.rx_bit ^ ref_q;
                ref_q     <= bus.rx_bit;
            end
        end
    end

    assign p           = s_q[6] ^ s_q[5];
    assign mismatch    = dec_bit_q ^ p;
    assign win_err_inc = win_err_q + EW'(mismatch);

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        seed_cnt_d  = seed_cnt_q;
        match_cnt_d = match_cnt_q;
        win_pos_d   = win_pos_q;
        win_err_d   = win_err_q;
        sync_lost_d = 1'b0;
        if (dec_valid_q) begin
            case (state_q)
                SEED: begin
                    s_d        = {s_q[5:0], dec_bit_q};
                    seed_cnt_d = seed_cnt_q + 3'd1;
                    if (seed_cnt_q == 3'd6) begin
                        state_d     = VERIFY;
                        match_cnt_d = '0;
                    end
                end
                VERIFY: begin
                    s_d = {s_q[5:0], dec_bit_q};
                    if (mismatch) begin
                        state_d    = SEED;
                        seed_cnt_d = '0;
                    end else begin
                        match_cnt_d = match_cnt_q + MW'(1);
                        if (match_cnt_q == MW'(LOCK_CNT - 1)) begin
                            state_d   = LOCKED;
                            win_pos_d = '0;
                            win_err_d = '0;
                        end
                    end
                end
                LOCKED: begin
                    // Free-run on the prediction so line errors cannot poison the reference sequence
                    s_d       = {s_q[5:0], p};
                    win_err_d = win_err_inc;
                    if (win_err_inc == EW'(LOSS_THRESH)) begin
                        state_d     = SEED;
                        seed_cnt_d  = '0;
                        sync_lost_d = 1'b1;
                    end else if (win_pos_q == PW'(WIN - 1)) begin
                        win_pos_d = '0;
                        win_err_d = '0;
                    end else begin
                        win_pos_d = win_pos_q + PW'(1);
                    end
                end
                default: state_d = SEED;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= SEED;
            s_q         <= '0;
            seed_cnt_q  <= '0;
            match_cnt_q <= '0;
            win_pos_q   <= '0;
            win_err_q   <= '0;
            sync_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            seed_cnt_q  <= seed_cnt_d;
            match_cnt_q <= match_cnt_d;
            win_pos_q   <= win_pos_d;
            win_err_q   <= win_err_d;
            sync_lost_q <= sync_lost_d;
        end
    end

`ifdef DPSK_DEMOD_ERRCNT_EN
    logic [ERRW-1:0] err_q, err_d;
    assign err_d = (dec_valid_q && state_q == LOCKED && mismatch && !(&err_q)) ? err_q + ERRW'(1) : err_q;
    always_ff @(posedge clk) begin
        if (!rst) err_q <= '0;
        else      err_q <= err_d;
    end
    assign bus.err_count = err_q;
`else
    assign bus.err_count = '0;
`endif

    assign bus.dec_bit   = dec_bit_q;
    assign bus.dec_valid = dec_valid_q;
    assign bus.locked    = (state_q == LOCKED);
    assign bus.sync_lost = sync_lost_q;
endmodule

// File: tb/tb_dpsk_demodulator.sv
// tb_dpsk_demodulator: directed stimulus with a behavioural reference model checked every cycle.
module tb_dpsk_demodulator;
    localparam int LOCK_CNT = 16;
    localparam int WIN      = 64;
    localparam int LOSS     = 8;
`ifdef DPSK_DEMOD_ERRCNT_EN
    localparam bit ERRCNT = 1'b1;
`else
    localparam bit ERRCNT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dpsk_demodulator_if #(.ERRW(16)) bus ();
    dpsk_demodulator dut (.clk(clk), .rst(rst), .bus(bus));

    int n_vec = 0;
    int n_err = 0;
    int sl_pulses = 0;
    bit cmp_en = 1'b0;

    bit m_hist[$];
    int m_mode, m_nseed, m_nmatch, m_wpos, m_werr, m_errs;
    bit m_ref, m_dbit, m_dval, m_sl;

    bit g_hist[$] = '{1, 1, 1, 1, 1, 1, 1};
    bit e_prev = 1'b0;

    task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_bit(bit d);
        bit p = m_hist[0] ^ m_hist[1];
        bit nxt = d;
        case (m_mode)
            0: begin
                m_nseed++;
                if (m_nseed == 7) begin m_mode = 1; m_nmatch = 0; end
            end
            1: begin
                if (d != p) begin m_mode = 0; m_nseed = 0; end
                else begin
                    m_nmatch++;
                    if (m_nmatch == LOCK_CNT) begin m_mode = 2; m_wpos = 0; m_werr = 0; end
                end
            end
            default: begin
                nxt = p;
                if (d != p) begin
                    m_werr++;
                    if (m_errs < 65535) m_errs++;
                end
                if (m_werr == LOSS) begin m_mode = 0; m_nseed = 0; m_sl = 1'b1; end
                else if (m_wpos == WIN - 1) begin m_wpos = 0; m_werr = 0; end
                else m_wpos++;
            end
        endcase
        m_hist.push_back(nxt);
        void'(m_hist.pop_front());
    endtask

    task automatic model_step(bit r, bit v, bit b);
        bit pd, pv;
        if (!r) begin
            m_hist = '{0, 0, 0, 0, 0, 0, 0};
            m_mode = 0; m_nseed = 0; m_nmatch = 0; m_wpos = 0; m_werr = 0; m_errs = 0;
            m_ref = 0; m_dbit = 0; m_dval = 0; m_sl = 0;
            return;
        end
        pd = m_dbit;
        pv = m_dval;
        m_sl = 1'b0;
        if (pv) chk_bit(pd);
        m_dval = v;
        if (v) begin
            m_dbit = b ^ m_ref;
            m_ref = b;
        end
    endtask

    task automatic tick(bit r, bit v, bit b);
        rst = r;
        bus.rx_valid = v;
        bus.rx_bit = b;
        @(posedge clk);
        model_step(r, v, b);
        #1;
    endtask

    function automatic bit prbs_next();
        bit nb = g_hist[0] ^ g_hist[1];
        g_hist.push_back(nb);
        void'(g_hist.pop_front());
        return nb;
    endfunction

    task automatic send(bit v, bit derr, bit eflip);
        bit d, e;
        if (v) begin
            d = prbs_next();
            e = d ^ derr ^ e_prev;
            e_prev = e;
            tick(1'b1, 1'b1, e ^ eflip);
        end else begin
            tick(1'b1, 1'b0, 1'($urandom));
        end
    endtask

    task automatic rst_tick();
        tick(1'b0, 1'b1, 1'($urandom));
        e_prev = 1'b0;
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            cmp("dec_valid", 32'(bus.dec_valid), 32'(m_dval));
            if (m_dval) cmp("dec_bit", 32'(bus.dec_bit), 32'(m_dbit));
            cmp("locked", 32'(bus.locked), 32'(m_mode == 2));
            cmp("sync_lost", 32'(bus.sync_lost), 32'(m_sl));
            cmp("err_count", 32'(bus.err_count), ERRCNT ? 32'(m_errs) : 32'd0);
            if (bus.sync_lost === 1'b1) sl_pulses++;
        end
    end

    initial begin
        bit ev[4] = '{1, 1, 0, 0};
        bit dv[4] = '{1, 0, 1, 0};
        bus.rx_valid = 1'b0;
        bus.rx_bit = 1'b0;
        rst_tick();
        rst_tick();
        cmp_en = 1'b1;
        cmp("rst_dec_valid", 32'(bus.dec_valid), 32'd0);
        cmp("rst_locked", 32'(bus.locked), 32'd0);
        cmp("rst_sync_lost", 32'(bus.sync_lost), 32'd0);
        cmp("rst_err_count", 32'(bus.err_count), 32'd0);

        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b1, ev[i]);
            cmp("decode_valid", 32'(bus.dec_valid), 32'd1);
            cmp("decode_bit", 32'(bus.dec_bit), 32'(dv[i]));
        end

        rst_tick();
        rst_tick();
        for (int i = 1; i <= 200; i++) begin
            send(1'b1, 1'b0, 1'b0);
            if (i == 23) cmp("lock_early", 32'(bus.locked), 32'd0);
            if (i == 24) cmp("lock_time", 32'(bus.locked), 32'd1);
        end
        cmp("clean_err_count", 32'(bus.err_count), 32'd0);

        for (int i = 201; i <= 230; i++) send(1'b1, 1'b0, i == 210);
        cmp("flip_err_count", 32'(bus.err_count), ERRCNT ? 32'd2 : 32'd0);
        cmp("flip_locked", 32'(bus.locked), 32'd1);
        cmp("flip_no_loss", 32'(sl_pulses), 32'd0);

        for (int i = 231; i <= 280; i++) begin
            send(1'b1, i >= 240 && i <= 247, 1'b0);
            if (i == 248) cmp("loss_pulse", 32'(bus.sync_lost), 32'd1);
            if (i == 248) cmp("loss_unlocked", 32'(bus.locked), 32'd0);
            if (i == 270) cmp("relock_early", 32'(bus.locked), 32'd0);
            if (i == 271) cmp("relock_time", 32'(bus.locked), 32'd1);
        end
        cmp("loss_pulse_count", 32'(sl_pulses), 32'd1);
        cmp("loss_err_count", 32'(bus.err_count), ERRCNT ? 32'd10 : 32'd0);

        rst_tick();
        cmp("midrst_dec_valid", 32'(bus.dec_valid), 32'd0);
        cmp("midrst_locked", 32'(bus.locked), 32'd0);
        cmp("midrst_sync_lost", 32'(bus.sync_lost), 32'd0);
        cmp("midrst_err_count", 32'(bus.err_count), 32'd0);

        for (int k = 1; k <= 30; k++) begin
            send(1'b1, 1'b0, 1'b0);
            if (k == 23) cmp("gap_lock_early", 32'(bus.locked), 32'd0);
            send(1'b0, 1'b0, 1'b0);
            if (k == 22) cmp("gap_lock_early2", 32'(bus.locked), 32'd0);
            if (k == 23) cmp("gap_lock_time", 32'(bus.locked), 32'd1);
        end

        @(negedge clk);
        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/dpsk_demodulator.md
Name: dpsk_demodulator

Overview:
- Receive-side stage directly downstream of the DPSK modulator.
- Consumes the differentially encoded serial bitstream, which is the modulator's xor_result, and recovers the data bits with d[n] = e[n] XOR e[n-1].
- Runs a self-synchronising PRBS checker on the recovered bits to declare lock, detect loss of sync and count bit errors.
- Used in loopback with the modulator for link bring-up and BER measurement.

Parameters:
- LOCK_CNT, 16: consecutive correct predicted bits required to declare lock.
- WIN, 64: length of the error-monitoring window in LOCKED, in decoded bits.
- LOSS_THRESH, 8: errors within one window that force loss of sync.
- ERRW, 16: width of err_count.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-low reset; clk is the only clock.
- rx_bit  input  1  differentially encoded bit from the modulator.
- rx_valid  input  1  rx_bit is qualified this cycle.
- dec_bit  output  1  recovered data bit.
- dec_valid  output  1  dec_bit is qualified; a single-cycle strobe per input bit.
- locked  output  1  PRBS checker is in the LOCKED state.
- sync_lost  output  1  one-cycle pulse on the LOCKED to SEED transition.
- err_count  output  ERRW  saturating count of bit errors detected while LOCKED.

Behaviour:
- Reset, sampled on the clk edge while rst=0:
  - outputs: dec_bit=0, dec_valid=0, locked=0, sync_lost=0, err_count=0;
  - internal state: differential reference bit=0, PRBS register=0, all counters=0, FSM=SEED.
- Differential decoder, stage 1:
  - On each rx_valid=1 cycle, register dec_bit <= rx_bit ^ ref, then ref <= rx_bit, and set dec_valid=1.
  - When rx_valid=0: dec_valid=0, and dec_bit and ref hold.
  - Latency: one cycle from rx_valid to dec_valid.
- PRBS checker, stage 2:
  - PRBS7, x^7+x^6+1, 7-bit register s.
  - Predicted bit p = s[6]^s[5]; the register shifts left with a new bit inserted at s[0].
  - The checker acts only on cycles where dec_valid=1; status outputs are registered, so they update one cycle after dec_valid.
- FSM:
  - SEED: shift dec_bit into s and increment seed_cnt. After 7 bits, go to VERIFY with match_cnt=0.
  - VERIFY: compare dec_bit with p, then shift dec_bit into s (self-synchronising).
    - On a match, match_cnt++; when match_cnt reaches LOCK_CNT, go to LOCKED with locked=1 and the window counters cleared.
    - On a mismatch, go to SEED with seed_cnt=0.
  - LOCKED: shift p into s (free-running, so received errors do not corrupt the sequence).
    - Each mismatch increments win_err, and increments err_count, which saturates at all ones.
    - win_pos counts 0..WIN-1. When a bit is processed at win_pos=WIN-1, win_pos and win_err are cleared.
    - When win_err reaches LOSS_THRESH, go to SEED with locked=0, sync_lost=1 for one cycle and seed_cnt=0; err_count is retained.
  - If the loss threshold and the window end occur on the same bit, loss of sync wins.
- err_count clears only on reset. It never wraps.
- rx_valid gaps of any length are transparent: every counter advances per valid bit, never per cycle.
- Reset asserted mid-operation, in any state, returns all state to reset values on that edge. No partial bit is retained.
- Lock time from reset with clean data: the 7th+LOCK_CNT-th decoded bit. With defaults that is bit 23; locked rises two cycles after that bit's rx_valid.

Optional Feature:
- Macro: DPSK_DEMOD_ERRCNT_EN.
- Defined: err_count logic is present as described.
- Undefined: the err_count port still exists but is tied to 0. Lock and loss detection use win_err only and are unchanged.

Test Plan:
- Reset: hold rst=0 for 2 cycles with rx_valid=1 -> dec_valid=0, locked=0, sync_lost=0, err_count=0.
- Decode: after reset, drive e=1,1,0,0 with rx_valid=1 -> dec_bit=1,0,1,0, each one cycle after its input, with dec_valid=1 on each.
- Lock: drive a differentially encoded PRBS7 from seed 7'h7F continuously -> locked=1 two cycles after the 23rd valid bit; err_count=0 after 200 bits.
- Single flip: while locked, invert one encoded bit -> two decoded errors, err_count=2, locked stays 1, sync_lost never pulses.
- Loss: while locked, inject decoded errors on 8 bits within one 64-bit window -> sync_lost pulses once, locked=0, FSM back in SEED; clean data then relocks after 23 bits.
- Gaps and mid-reset:
  - Repeat the lock test with rx_valid alternating 1/0 -> lock occurs on the same 23rd valid bit.
  - Assert rst=0 for one cycle while locked -> all outputs are at reset values on the next cycle.
